// File: rtl/core_wb_arbiter_pkg.sv
// Shared writeback types: register number, data word, write-port line and
// the queued {rd, value} entry held by each requester FIFO.
package core_wb_arbiter_pkg;

    localparam int REG_W  = 5;
    localparam int WORD_W = 32;

    typedef logic [REG_W-1:0]  reg_num;
    typedef logic [WORD_W-1:0] word;

    // One register-file write port: ready qualifies rd/value.
    typedef struct packed {
        logic   ready;
        reg_num rd;
        word    value;
    } wb_line;

    // Payload stored per FIFO slot.
    typedef struct packed {
        reg_num rd;
        word    value;
    } wb_entry;

    // Hard-wired zero register; writes to it are meaningless.
    localparam reg_num R0 = 5'd0;

    // Default number of writeback producers.
    localparam int WB_SRCS = 4;

    // Quiet port value used at reset, on flush and when nothing is granted.
    localparam wb_line WB_IDLE = '{ready: 1'b0, rd: R0, value: 32'd0};

endpackage

// File: rtl/core_wb_arbiter_fifo.sv
// Per-requester writeback queue: DEPTH slots of {rd, value}, natural pointer
// wrap, count one bit wider than the pointers so full and empty differ.
module core_wb_arbiter_fifo
    import core_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
)(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  wb_entry                    din,
    output wb_entry                    head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry         mem_r [DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;

    // Storage and pointer/count bookkeeping; flush empties the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r <= count_r + CW'(push) - CW'(pop);
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = (count_r == CW'(DEPTH));

endmodule

// File: rtl/core_wb_arbiter.sv
// Writeback arbiter: NUM_SRC queued producers share two register-file write
// ports. A round-robin scan grants up to two FIFO heads per cycle and never
// lets both ports target the same register.
module core_wb_arbiter
    import core_wb_arbiter_pkg::*;
#(
    parameter int NUM_SRC = WB_SRCS,
    parameter int DEPTH   = 2
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic [NUM_SRC-1:0] src_valid,
    input  reg_num             src_rd    [NUM_SRC],
    input  word                src_value [NUM_SRC],
    output logic [NUM_SRC-1:0] src_ready,
    output wb_line             wr_a,
    output wb_line             wr_b,
    output logic               busy
);

    localparam int SW = $clog2(NUM_SRC);
    localparam int CW = $clog2(DEPTH) + 1;

    wb_entry            head_s  [NUM_SRC];
    logic [CW-1:0]      count_s [NUM_SRC];
    logic [NUM_SRC-1:0] full_s;
    logic [NUM_SRC-1:0] push_s;
    logic [NUM_SRC-1:0] pop_s;
    logic [NUM_SRC-1:0] nonempty_s;

    logic               grant_a_s;
    logic               grant_b_s;
    logic [SW-1:0]      a_idx_s;
    logic [SW-1:0]      b_idx_s;
    logic [SW-1:0]      last_idx_s;

    logic [SW-1:0]      rr_ptr_r;
    wb_line             wr_a_r;
    wb_line             wr_b_r;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        // Writes to R0 are acknowledged but never stored.
        assign push_s[g]     = src_valid[g] && !full_s[g] && !flush && (src_rd[g] != R0);
        assign nonempty_s[g] = (count_s[g] != CW'(0));
        assign src_ready[g]  = !full_s[g];

        core_wb_arbiter_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .flush (flush),
            .push  (push_s[g]),
            .pop   (pop_s[g]),
            .din   ('{rd: src_rd[g], value: src_value[g]}),
            .head  (head_s[g]),
            .count (count_s[g]),
            .full  (full_s[g])
        );
    end

    // Round-robin scan from rr_ptr: first non-empty head wins port A, the next
    // one with a different rd wins port B; same-rd heads wait a cycle.
    always_comb begin
        int idx;
        idx       = 0;
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        a_idx_s   = '0;
        b_idx_s   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = (int'(rr_ptr_r) + k) % NUM_SRC;
            if (nonempty_s[idx]) begin
                if (!grant_a_s) begin
                    grant_a_s = 1'b1;
                    a_idx_s   = SW'(idx);
                end else if (!grant_b_s && (head_s[idx].rd != head_s[a_idx_s].rd)) begin
                    grant_b_s = 1'b1;
                    b_idx_s   = SW'(idx);
                end else begin
                    idx = idx;
                end
            end else begin
                idx = idx;
            end
        end
    end

    // Granted heads pop at the edge their data is registered onto a port.
    always_comb begin
        pop_s = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!flush && ((grant_a_s && (a_idx_s == SW'(i))) ||
                           (grant_b_s && (b_idx_s == SW'(i))))) begin
                pop_s[i] = 1'b1;
            end else begin
                pop_s[i] = 1'b0;
            end
        end
    end

    // Port B is always later in scan order than port A, so it is the last grant.
    always_comb begin
        if (grant_b_s) begin
            last_idx_s = b_idx_s;
        end else begin
            last_idx_s = a_idx_s;
        end
    end

    // Registered write ports and round-robin pointer; flush keeps the pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_a_r   <= WB_IDLE;
            wr_b_r   <= WB_IDLE;
            rr_ptr_r <= '0;
        end else if (flush) begin
            wr_a_r   <= WB_IDLE;
            wr_b_r   <= WB_IDLE;
        end else begin
            wr_a_r <= grant_a_s ? '{ready: 1'b1, rd: head_s[a_idx_s].rd, value: head_s[a_idx_s].value}
                                : WB_IDLE;
            wr_b_r <= grant_b_s ? '{ready: 1'b1, rd: head_s[b_idx_s].rd, value: head_s[b_idx_s].value}
                                : WB_IDLE;
            if (grant_a_s) begin
                rr_ptr_r <= SW'((int'(last_idx_s) + 1) % NUM_SRC);
            end
        end
    end

    assign wr_a = wr_a_r;
    assign wr_b = wr_b_r;
    assign busy = (|nonempty_s) | wr_a_r.ready | wr_b_r.ready;

endmodule

// File: tb/tb_core_wb_arbiter.sv
// Self-checking bench for core_wb_arbiter: directed scenarios plus a random
// run, all compared against a queue-based reference model.
module tb_core_wb_arbiter;
    import core_wb_arbiter_pkg::*;

    localparam int N = 4;
    localparam int D = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic [N-1:0] src_valid = '0;
    reg_num       src_rd    [N];
    word          src_value [N];
    logic [N-1:0] src_ready;
    wb_line       wr_a;
    wb_line       wr_b;
    logic         busy;

    int checks = 0;
    int failures = 0;

    typedef struct { reg_num rd; word value; } ent_t;
    ent_t         mq [N][$];
    int           m_rr;
    wb_line       exp_a;
    wb_line       exp_b;
    logic [N-1:0] m_acc;

    core_wb_arbiter #(.NUM_SRC(N), .DEPTH(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .src_valid (src_valid),
        .src_rd    (src_rd),
        .src_value (src_value),
        .src_ready (src_ready),
        .wr_a      (wr_a),
        .wr_b      (wr_b),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] m_ready();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = (mq[i].size() < D);
        return r;
    endfunction

    function automatic logic m_busy();
        logic b;
        b = exp_a.ready | exp_b.ready;
        for (int i = 0; i < N; i++) if (mq[i].size() > 0) b = 1'b1;
        return b;
    endfunction

    // Reference model: one clock edge worth of queue behaviour.
    task automatic model_edge();
        int ga, gb, s;
        ga = -1; gb = -1;
        if (flush) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            exp_a = WB_IDLE; exp_b = WB_IDLE; m_acc = '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                s = (m_rr + k) % N;
                if (mq[s].size() > 0) begin
                    if (ga < 0) ga = s;
                    else if (gb < 0 && mq[s][0].rd != mq[ga][0].rd) gb = s;
                end
            end
            exp_a = (ga >= 0) ? '{ready: 1'b1, rd: mq[ga][0].rd, value: mq[ga][0].value} : WB_IDLE;
            exp_b = (gb >= 0) ? '{ready: 1'b1, rd: mq[gb][0].rd, value: mq[gb][0].value} : WB_IDLE;
            for (int i = 0; i < N; i++) m_acc[i] = src_valid[i] && (mq[i].size() < D);
            if (ga >= 0) void'(mq[ga].pop_front());
            if (gb >= 0) void'(mq[gb].pop_front());
            for (int i = 0; i < N; i++)
                if (m_acc[i] && src_rd[i] != R0) mq[i].push_back('{rd: src_rd[i], value: src_value[i]});
            if (gb >= 0) m_rr = (gb + 1) % N;
            else if (ga >= 0) m_rr = (ga + 1) % N;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic clear_inputs();
        src_valid = '0;
        flush = 1'b0;
        for (int i = 0; i < N; i++) begin
            src_rd[i] = R0;
            src_value[i] = 32'd0;
        end
    endtask

    task automatic reset_dut();
        clear_inputs();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) mq[i].delete();
        m_rr = 0; exp_a = WB_IDLE; exp_b = WB_IDLE; m_acc = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_dut();
        src_valid = 4'b0111;
        src_rd[0] = 5'd1; src_rd[1] = 5'd2; src_rd[2] = 5'd3;
        tick(); tick();
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) mq[i].delete();
        m_rr = 0; exp_a = WB_IDLE; exp_b = WB_IDLE;
        #1;
        checks++; if (wr_a !== WB_IDLE) begin failures++; $display("FAIL reset_wr_a: got %h want %h", wr_a, WB_IDLE); end
        checks++; if (wr_b !== WB_IDLE) begin failures++; $display("FAIL reset_wr_b: got %h want %h", wr_b, WB_IDLE); end
        checks++; if (src_ready !== 4'b1111) begin failures++; $display("FAIL reset_src_ready: got %b want 1111", src_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (dut.rr_ptr_r !== 2'd0) begin failures++; $display("FAIL reset_rr: got %0d want 0", dut.rr_ptr_r); end
        clear_inputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        checks++; if (wr_a.ready !== 1'b0 || wr_b.ready !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL reset_idle: got a=%b b=%b busy=%b want 0 0 0", wr_a.ready, wr_b.ready, busy);
        end
    endtask

    task automatic test_single();
        wb_line e;
        reset_dut();
        src_valid = 4'b0001; src_rd[0] = 5'd3; src_value[0] = 32'h11;
        tick();
        clear_inputs();
        checks++; if (wr_a.ready !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL single_edge1: got ready=%b busy=%b want 0 1", wr_a.ready, busy);
        end
        tick();
        e = '{ready: 1'b1, rd: 5'd3, value: 32'h11};
        checks++; if (wr_a !== e) begin failures++; $display("FAIL single_wr_a: got %h want %h", wr_a, e); end
        checks++; if (wr_b.ready !== 1'b0) begin failures++; $display("FAIL single_wr_b: got %b want 0", wr_b.ready); end
        checks++; if (dut.g_src[0].u_fifo.count_r !== 2'd0) begin
            failures++; $display("FAIL single_fifo0_count: got %0d want 0", dut.g_src[0].u_fifo.count_r);
        end
    endtask

    task automatic test_three();
        wb_line e;
        reset_dut();
        src_valid = 4'b0111;
        src_rd[0] = 5'd1; src_value[0] = 32'hA;
        src_rd[1] = 5'd2; src_value[1] = 32'hB;
        src_rd[2] = 5'd4; src_value[2] = 32'hC;
        tick();
        clear_inputs();
        tick();
        e = '{ready: 1'b1, rd: 5'd1, value: 32'hA};
        checks++; if (wr_a !== e) begin failures++; $display("FAIL three_a1: got %h want %h", wr_a, e); end
        e = '{ready: 1'b1, rd: 5'd2, value: 32'hB};
        checks++; if (wr_b !== e) begin failures++; $display("FAIL three_b1: got %h want %h", wr_b, e); end
        tick();
        e = '{ready: 1'b1, rd: 5'd4, value: 32'hC};
        checks++; if (wr_a !== e) begin failures++; $display("FAIL three_a2: got %h want %h", wr_a, e); end
        checks++; if (wr_b.ready !== 1'b0) begin failures++; $display("FAIL three_b2: got %b want 0", wr_b.ready); end
        checks++; if (dut.rr_ptr_r !== 2'd3) begin failures++; $display("FAIL three_rr: got %0d want 3", dut.rr_ptr_r); end
    endtask

    task automatic test_same_rd();
        wb_line e;
        reset_dut();
        src_valid = 4'b0001; src_rd[0] = 5'd9; src_value[0] = 32'h99;
        tick();
        clear_inputs();
        src_valid = 4'b0110;
        src_rd[1] = 5'd5; src_value[1] = 32'h55;
        src_rd[2] = 5'd5; src_value[2] = 32'h66;
        tick();
        clear_inputs();
        checks++; if (dut.rr_ptr_r !== 2'd1) begin failures++; $display("FAIL same_rd_rr: got %0d want 1", dut.rr_ptr_r); end
        tick();
        e = '{ready: 1'b1, rd: 5'd5, value: 32'h55};
        checks++; if (wr_a !== e) begin failures++; $display("FAIL same_rd_a1: got %h want %h", wr_a, e); end
        checks++; if (wr_b.ready !== 1'b0) begin failures++; $display("FAIL same_rd_b1: got %b want 0", wr_b.ready); end
        tick();
        e = '{ready: 1'b1, rd: 5'd5, value: 32'h66};
        checks++; if (wr_a !== e) begin failures++; $display("FAIL same_rd_a2: got %h want %h", wr_a, e); end
    endtask

    task automatic test_back_to_back();
        int n3;
        wb_line seen[$];
        wb_line e;
        reset_dut();
        n3 = 0;
        for (int c = 0; c < 30; c++) begin
            for (int i = 0; i < 3; i++) begin
                src_valid[i] = (c < 8);
                src_rd[i] = reg_num'(8 + i);
                src_value[i] = $urandom;
            end
            src_valid[3] = (n3 < 3);
            src_rd[3] = reg_num'(20 + n3);
            src_value[3] = 32'h300 + 32'(n3);
            tick();
            if (m_acc[3]) n3++;
            if (c == 1) begin
                checks++; if (src_ready[3] !== 1'b0) begin failures++; $display("FAIL b2b_full: got %b want 0", src_ready[3]); end
            end
            checks++; if (wr_a !== exp_a || wr_b !== exp_b) begin
                failures++; $display("FAIL b2b_ports c=%0d: got %h/%h want %h/%h", c, wr_a, wr_b, exp_a, exp_b);
            end
            checks++; if (src_ready !== m_ready()) begin
                failures++; $display("FAIL b2b_ready c=%0d: got %b want %b", c, src_ready, m_ready());
            end
            if (wr_a.ready && wr_a.rd >= 5'd20) seen.push_back(wr_a);
            if (wr_b.ready && wr_b.rd >= 5'd20) seen.push_back(wr_b);
        end
        clear_inputs();
        checks++; if (seen.size() != 3) begin failures++; $display("FAIL b2b_count: got %0d want 3", seen.size()); end
        for (int k = 0; k < 3 && k < seen.size(); k++) begin
            e = '{ready: 1'b1, rd: reg_num'(20 + k), value: 32'h300 + 32'(k)};
            checks++; if (seen[k] !== e) begin failures++; $display("FAIL b2b_order%0d: got %h want %h", k, seen[k], e); end
        end
    endtask

    task automatic test_flush();
        reset_dut();
        src_valid = 4'b0011;
        src_rd[0] = 5'd6; src_value[0] = 32'h60;
        src_rd[1] = 5'd7; src_value[1] = 32'h70;
        tick();
        clear_inputs();
        flush = 1'b1;
        src_valid = 4'b0100; src_rd[2] = 5'd10; src_value[2] = 32'hA0;
        tick();
        clear_inputs();
        checks++; if (wr_a.ready !== 1'b0 || wr_b.ready !== 1'b0) begin
            failures++; $display("FAIL flush_ports: got %b %b want 0 0", wr_a.ready, wr_b.ready);
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy: got %b want 0", busy); end
        checks++; if (src_ready !== 4'b1111) begin failures++; $display("FAIL flush_ready: got %b want 1111", src_ready); end
        checks++; if (dut.rr_ptr_r !== 2'd0) begin failures++; $display("FAIL flush_rr: got %0d want 0", dut.rr_ptr_r); end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (wr_a.ready !== 1'b0 || wr_b.ready !== 1'b0) begin
                failures++; $display("FAIL flush_quiet c=%0d: got %b %b want 0 0", c, wr_a.ready, wr_b.ready);
            end
        end
        src_valid = 4'b0001; src_rd[0] = R0; src_value[0] = 32'hDEAD;
        tick();
        clear_inputs();
        checks++; if (busy !== 1'b0 || src_ready !== 4'b1111) begin
            failures++; $display("FAIL r0_push: got busy=%b ready=%b want 0 1111", busy, src_ready);
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++; if (wr_a.ready !== 1'b0 || wr_b.ready !== 1'b0 || busy !== 1'b0) begin
                failures++; $display("FAIL r0_quiet c=%0d: got %b %b busy=%b want 0 0 0", c, wr_a.ready, wr_b.ready, busy);
            end
        end
    endtask

    task automatic test_random();
        reset_dut();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                src_valid[i] = ($urandom_range(0, 2) != 0);
                src_rd[i] = reg_num'($urandom_range(0, 7));
                src_value[i] = $urandom;
            end
            flush = ($urandom_range(0, 19) == 0);
            tick();
            checks++; if (wr_a !== exp_a) begin failures++; $display("FAIL rand_wr_a c=%0d: got %h want %h", c, wr_a, exp_a); end
            checks++; if (wr_b !== exp_b) begin failures++; $display("FAIL rand_wr_b c=%0d: got %h want %h", c, wr_b, exp_b); end
            checks++; if (src_ready !== m_ready()) begin failures++; $display("FAIL rand_ready c=%0d: got %b want %b", c, src_ready, m_ready()); end
            checks++; if (busy !== m_busy()) begin failures++; $display("FAIL rand_busy c=%0d: got %b want %b", c, busy, m_busy()); end
            checks++; if (dut.rr_ptr_r !== 2'(m_rr)) begin failures++; $display("FAIL rand_rr c=%0d: got %0d want %0d", c, dut.rr_ptr_r, m_rr); end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single();
        test_three();
        test_same_rd();
        test_back_to_back();
        test_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/core_wb_arbiter.md
Name: core_wb_arbiter

Overview:
- Shares the two register-file write ports (wr_a, wr_b) between NUM_SRC writeback producers: ALU, load, multiply, and so on.
- Each producer gets a small FIFO with a valid/ready handshake.
- A round-robin scheduler drains up to two FIFO heads per cycle onto registered wb_line outputs.
- Sits between the execute/memory units and core_regs, and guarantees that the two ports never target the same register in one cycle.

Parameters:
- NUM_SRC, 4, number of writeback requesters (2..8).
- DEPTH, 2, entries per requester FIFO (power of two, >=2).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  discard all queued and outgoing writebacks
- src_valid  in  NUM_SRC  requester i presents a writeback
- src_rd  in  NUM_SRC x reg_num  destination register per requester
- src_value  in  NUM_SRC x word  result value per requester
- src_ready  out  NUM_SRC  requester i FIFO can accept
- wr_a  out  wb_line  write port A (ready, rd, value) to core_regs
- wr_b  out  wb_line  write port B (ready, rd, value) to core_regs
- busy  out  1  any FIFO non-empty or any output port ready

Behaviour:
- Reset (async, rst_n=0):
  - all FIFOs empty; rr_ptr=0.
  - wr_a.ready=0, wr_b.ready=0; wr_*.rd=`R0; wr_*.value=0.
  - src_ready=all ones; busy=0.
- Enqueue:
  - Entry accepted at a rising edge when src_valid[i] && src_ready[i].
  - src_ready[i] = (count[i] != DEPTH), computed from registered count only. There is no bypass: a full FIFO refuses a push even when its head is granted in the same cycle.
- rd == `R0 requests:
  - Accepted and dropped at enqueue; they never occupy a slot and never reach the ports.
- Head eligibility:
  - FIFO i is eligible when non-empty.
- Arbitration (combinational over heads, every cycle):
  - Scan i = rr_ptr, rr_ptr+1, ... mod NUM_SRC.
  - First eligible head -> grant A.
  - Next eligible head whose rd differs from grant A's rd -> grant B.
  - An eligible head with the same rd as grant A is skipped this cycle and stays queued.
  - At most one grant per FIFO per cycle.
- Outputs:
  - Registered. At the edge after arbitration, wr_a and wr_b take {1, rd, value} of grants A and B, or ready=0 when there is no grant.
  - Granted heads pop at that same edge.
  - Latency: an entry accepted at edge t appears on a port no earlier than edge t+1, and is written to the file at edge t+2.
- Pointer update:
  - rr_ptr <= (index of last granted source + 1) mod NUM_SRC.
  - Unchanged when nothing is granted.
- Ordering:
  - Per-requester FIFO order is preserved.
  - There is no ordering between requesters; the issue stage must not have two in-flight writes to the same rd from different units.
- Simultaneous push and pop on the same FIFO: count unchanged, pointers both advance.
- Wrap-around: read/write pointers are log2(DEPTH) bits wide and wrap naturally; count is log2(DEPTH)+1 bits wide.
- Flush (synchronous, highest priority):
  - At the edge: all counts=0; wr_a.ready=wr_b.ready=0; rr_ptr unchanged.
  - Pushes presented in the flush cycle are discarded.
- Reset mid-operation: immediately returns to the reset state; queued data is lost.
- busy = |count | wr_a.ready | wr_b.ready.

Decomposition:
- The wb_line, reg_num and word typedefs and `R0 already live in core/uarch.sv. Add `WB_SRCS, the default NUM_SRC, there.
- Sub-module core_wb_arbiter_fifo: one per requester, DEPTH entries of {rd, value}, exposing push, pop, head, count and full.
- The round-robin scan plus the same-rd check stays in the top module.

Test Plan:
- Reset, then no stimulus -> wr_a.ready=wr_b.ready=0, src_ready=4'b1111, busy=0.
- Src0 pushes {r3, 0x11} at edge 1 -> wr_a={1, r3, 0x11} after edge 2, wr_b.ready=0, FIFO0 empty after edge 2.
- Srcs 0, 1, 2 push {r1, 0xA}, {r2, 0xB}, {r4, 0xC} in the same cycle with rr_ptr=0 -> next cycle wr_a=r1, wr_b=r2; following cycle wr_a=r4; rr_ptr ends at 3.
- Srcs 1 and 2 both hold head rd=r5 (0x55, 0x66), rr_ptr=1 -> cycle 1 wr_a={r5, 0x55}, wr_b.ready=0; cycle 2 wr_a={r5, 0x66}.
- Src3 pushes 3 entries back-to-back with DEPTH=2 and the ports kept busy by srcs 0-2 -> src_ready[3]=0 after two accepts; the third push waits; all three reach the ports in push order.
- Two entries queued, flush=1 in the same cycle as a new push -> after that edge counts=0, wr_*.ready=0, busy=0; the pushed entry never appears. A push of rd=`R0 is consumed with no port activity.
